// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for the CPU datapath. It steps each instruction
//   through FETCH -> DECODE -> EXECUTE -> WRITE_BACK. It waits on instr_mem
//   wait-states in FETCH and on ALU completion in EXECUTE. It gates the
//   pc_cntrl advance and regbank write strobes. It also counts retired
//   instructions and raises a sticky fault if a fetch stalls too long.
//
//   Optional feature: define DEBUG_STEP_EN to add single-step debug control.
//   In that build, each WRITE_BACK parks in STEP_WAIT while dbg_step_mode is
//   set, until the core receives a dbg_step pulse.
//
// Ports
//   clk            in   clock, all state updates on posedge
//   reset          in   asynchronous, active-high reset
//   imem_ready     in   instr_mem holds a valid instruction for current pc
//   halt_req       in   decoder flags current instruction as halt
//   is_branch      in   decoder: current instruction is a branch
//   branch_cond    in   branch condition from regbank
//   alu_done       in   ALU result valid
//   dbg_step_mode  in   (DEBUG_STEP_EN only) park after every instruction
//   dbg_step       in   (DEBUG_STEP_EN only) release one instruction
//   fetch_req      out  request instruction at pc
//   ir_load        out  latch decoder inputs
//   pc_enable      out  advance pc_cntrl
//   take_branch    out  pc_cntrl takes the branch this cycle
//   rf_write_en    out  regbank write strobe
//   state          out  current FSM state
//   halted         out  FSM is in HALT
//   fault          out  sticky fetch-timeout fault
//   retired        out  instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int RETIRE_W      = 32,
  parameter int FETCH_TIMEOUT = 15,
  parameter int TMO_W         = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                imem_ready,
  input  logic                halt_req,
  input  logic                is_branch,
  input  logic                branch_cond,
  input  logic                alu_done,
`ifdef DEBUG_STEP_EN
  input  logic                dbg_step_mode,
  input  logic                dbg_step,
`endif
  output logic                fetch_req,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                take_branch,
  output logic                rf_write_en,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] ST_FETCH      = 3'd0;
  localparam logic [2:0] ST_DECODE     = 3'd1;
  localparam logic [2:0] ST_EXECUTE    = 3'd2;
  localparam logic [2:0] ST_WRITE_BACK = 3'd3;
  localparam logic [2:0] ST_HALT       = 3'd4;
  localparam logic [2:0] ST_STEP_WAIT  = 3'd5;

  // Wait count value seen on the last permitted FETCH cycle without ready.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [TMO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                fault_q, fault_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                step_mode;
  logic                tmo_hit;

`ifdef DEBUG_STEP_EN
  assign step_mode = dbg_step_mode;
`else
  assign step_mode = 1'b0;
`endif

  assign tmo_hit = (FETCH_TIMEOUT != 0) && (wait_cnt_q == TMO_LAST);

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    fault_d    = fault_q;
    retired_d  = retired_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (tmo_hit) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DECODE:  state_d = halt_req ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: if (alu_done) state_d = ST_WRITE_BACK;
      ST_WRITE_BACK: begin
        retired_d = retired_q + 1'b1;
        state_d   = step_mode ? ST_STEP_WAIT : ST_FETCH;
      end
      ST_HALT:    state_d = ST_HALT;
`ifdef DEBUG_STEP_EN
      // Leave when released by a step pulse or when step mode is switched off.
      ST_STEP_WAIT: if (!dbg_step_mode || dbg_step) state_d = ST_FETCH;
`endif
      default:    state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
    end
  end

  // Moore strobes decoded from the registered state. take_branch and
  // rf_write_en are also qualified by the decoder flags during WRITE_BACK.
  always_comb begin
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    pc_enable   = 1'b0;
    take_branch = 1'b0;
    rf_write_en = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FETCH:  fetch_req = 1'b1;
      ST_DECODE: ir_load   = 1'b1;
      ST_WRITE_BACK: begin
        pc_enable   = 1'b1;
        rf_write_en = !is_branch;
        take_branch = is_branch & branch_cond;
      end
      ST_HALT:   halted    = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed, self-checking bench for cpu_sequencer with default parameters
//   (FETCH_TIMEOUT = 15). It drives inputs 1 time unit after each rising edge
//   and samples outputs at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, halt_req, is_branch, branch_cond, alu_done;
`ifdef DEBUG_STEP_EN
  logic        dbg_step_mode, dbg_step;
`endif
  logic        fetch_req, ir_load, pc_enable, take_branch, rf_write_en;
  logic [2:0]  state;
  logic        halted, fault;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .halt_req     (halt_req),
    .is_branch    (is_branch),
    .branch_cond  (branch_cond),
    .alu_done     (alu_done),
`ifdef DEBUG_STEP_EN
    .dbg_step_mode(dbg_step_mode),
    .dbg_step     (dbg_step),
`endif
    .fetch_req    (fetch_req),
    .ir_load      (ir_load),
    .pc_enable    (pc_enable),
    .take_branch  (take_branch),
    .rf_write_en  (rf_write_en),
    .state        (state),
    .halted       (halted),
    .fault        (fault),
    .retired      (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes packed as {fetch_req, ir_load, pc_enable, take_branch, rf_write_en}.
  function automatic logic [31:0] strobes();
    return {27'd0, fetch_req, ir_load, pc_enable, take_branch, rf_write_en};
  endfunction

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0; halt_req = 1'b0; is_branch = 1'b0;
    branch_cond = 1'b0; alu_done = 1'b0;
`ifdef DEBUG_STEP_EN
    dbg_step_mode = 1'b0; dbg_step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    // Outputs while in reset.
    check("rst_state",   32'(state),   32'd0);
    check("rst_strobes", strobes(),    32'b10000);
    check("rst_halted",  32'(halted),  32'd0);
    check("rst_fault",   32'(fault),   32'd0);
    check("rst_retired", retired,      32'd0);
    reset = 1'b0;

    // T1: back-to-back non-branch instructions, 4 cycles each.
    imem_ready = 1'b1; alu_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1_state_c%0d", i + 1), 32'(state), 32'(i % 4));
      check($sformatf("t1_rfwe_c%0d", i + 1), 32'(rf_write_en), 32'((i % 4) == 3));
      step();
    end
    check("t1_retired", retired, 32'd3);
    check("t1_state_end", 32'(state), 32'd0);

    // T2: five wait-states in FETCH, then ready.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_fetch_c%0d", i + 1), 32'(state), 32'd0);
      check($sformatf("t2_freq_c%0d", i + 1), 32'(fetch_req), 32'd1);
      step();
    end
    imem_ready = 1'b1;
    check("t2_fetch_c6", 32'(state), 32'd0);
    step();
    check("t2_decode", 32'(state), 32'd1);
    check("t2_irload", strobes(), 32'b01000);
    check("t2_fault",  32'(fault), 32'd0);
    // EXECUTE holds while alu_done is low.
    alu_done = 1'b0;
    step();
    check("t2_exec0", 32'(state), 32'd2);
    step();
    check("t2_exec_hold", 32'(state), 32'd2);
    check("t2_exec_strb", strobes(), 32'b00000);
    alu_done = 1'b1;
    step();
    check("t2_wb_state", 32'(state), 32'd3);
    check("t2_wb_strb",  strobes(), 32'b00101);
    step();
    check("t2_retired",  retired, 32'd4);

    // T4: branch taken, then branch not taken.
    is_branch = 1'b1; branch_cond = 1'b1;
    repeat (3) step();
    check("t4_tk_state", 32'(state), 32'd3);
    check("t4_tk_strb",  strobes(), 32'b00110);
    step();
    check("t4_tk_ret",   retired, 32'd5);
    branch_cond = 1'b0;
    repeat (3) step();
    check("t4_nt_state", 32'(state), 32'd3);
    check("t4_nt_strb",  strobes(), 32'b00100);
    step();
    check("t4_nt_ret",   retired, 32'd6);
    is_branch = 1'b0;

    // T5a: asynchronous reset in the middle of EXECUTE.
    alu_done = 1'b0;
    repeat (2) step();
    check("t5_pre_exec", 32'(state), 32'd2);
    reset = 1'b1;
    #1;
    check("t5_arst_state",   32'(state), 32'd0);
    check("t5_arst_retired", retired,    32'd0);
    check("t5_arst_strb",    strobes(),  32'b10000);
    @(posedge clk); #1;
    reset = 1'b0;
    alu_done = 1'b1;

    // T5b: one retired instruction, then halt in DECODE without retiring.
    repeat (4) step();
    check("t5_ret1", retired, 32'd1);
    halt_req = 1'b1;
    repeat (2) step();
    halt_req = 1'b0;
    check("t5_halt_state",  32'(state),  32'd4);
    check("t5_halt_halted", 32'(halted), 32'd1);
    check("t5_halt_ret",    retired,     32'd1);
    check("t5_halt_fault",  32'(fault),  32'd0);
    step();
    check("t5_halt_stay",   32'(state),  32'd4);

    // T3: fetch timeout after 15 FETCH cycles without ready.
    reset = 1'b1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t3_fetch_c%0d", i + 1), 32'(state), 32'd0);
      step();
    end
    check("t3_state",  32'(state),  32'd4);
    check("t3_fault",  32'(fault),  32'd1);
    check("t3_halted", 32'(halted), 32'd1);
    // HALT ignores all inputs until the next reset.
    imem_ready = 1'b1; alu_done = 1'b1; is_branch = 1'b1; branch_cond = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t3_hold_strb%0d", i), strobes(), 32'b00000);
      check($sformatf("t3_hold_st%0d", i), {28'd0, fault, state}, 32'hC);
    end
    is_branch = 1'b0; branch_cond = 1'b0;

`ifdef DEBUG_STEP_EN
    // T6: single-step mode.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dbg_step_mode = 1'b1;
    repeat (4) step();
    check("t6_park_state", 32'(state), 32'd5);
    check("t6_park_ret",   retired,    32'd1);
    repeat (3) step();
    check("t6_hold_state", 32'(state), 32'd5);
    check("t6_hold_strb",  strobes(),  32'b00000);
    dbg_step = 1'b1;
    step();
    dbg_step = 1'b0;
    check("t6_release", 32'(state), 32'd0);
    repeat (4) step();
    check("t6_park2_state", 32'(state), 32'd5);
    check("t6_park2_ret",   retired,    32'd2);
    dbg_step_mode = 1'b0;
    step();
    check("t6_mode_off", 32'(state), 32'd0);
    check("t6_mode_ret", retired,    32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
